// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared state encoding and constants for the factorial controller
package fact_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_MAX_N = 12;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_MULT  = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        CHECK = ST_CHECK,
        MULT  = ST_MULT,
        FIN   = ST_FIN
    } state_t;

    // Product register mux select values
    localparam logic PROD_ONE = 1'b0;
    localparam logic PROD_MUL = 1'b1;

endpackage

// File: rtl/fact_ctrl_if.sv
// rtl/fact_ctrl_if.sv - request, counter and product control signals of the factorial controller
interface fact_ctrl_if #(
    parameter int WIDTH = 4
);

    logic             GO;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] CNT_Q;
    logic             CNT_LD;
    logic             CNT_EN;
    logic [WIDTH-1:0] CNT_D;
    logic             PROD_LD;
    logic             PROD_SEL;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    // Requester/datapath side
    modport master (
        output GO, N, CNT_Q,
        input  CNT_LD, CNT_EN, CNT_D, PROD_LD, PROD_SEL, BUSY, DONE, ERR
    );

    // Controller side
    modport slave (
        input  GO, N, CNT_Q,
        output CNT_LD, CNT_EN, CNT_D, PROD_LD, PROD_SEL, BUSY, DONE, ERR
    );

endinterface

// File: rtl/fact_ctrl.sv
// rtl/fact_ctrl.sv - Moore control FSM sequencing the down-counter and product register
module fact_ctrl
    import fact_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int MAX_N = DEFAULT_MAX_N
) (
    input  logic        CLK,
    input  logic        RST_N,
    fact_ctrl_if.slave  bus
);

    // Limit and terminal count expressed on WIDTH bits so all compares stay unsigned
    localparam logic [WIDTH-1:0] MAX_N_W = WIDTH'(MAX_N);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] n_q;
    logic             err_q;

    logic go_accept;
    logic go_reject;

    // GO only matters in IDLE; it is ignored while busy
    assign go_accept = (state_q == IDLE) && bus.GO && (bus.N <= MAX_N_W);
    assign go_reject = (state_q == IDLE) && bus.GO && (bus.N >  MAX_N_W);

    // State, captured operand and sticky error flag
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            n_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go_accept) begin
                n_q   <= bus.N;
                err_q <= 1'b0;
            end else if (go_reject) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go_accept) state_d = LOAD;
            LOAD:    state_d = CHECK;
            CHECK:   state_d = (bus.CNT_Q <= ONE_W) ? FIN : MULT;
            MULT:    state_d = CHECK;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state register only; LOAD and MULT never overlap,
    // so CNT_LD and CNT_EN are mutually exclusive by construction
    always_comb begin
        bus.CNT_LD   = 1'b0;
        bus.CNT_EN   = 1'b0;
        bus.PROD_LD  = 1'b0;
        bus.PROD_SEL = PROD_ONE;
        bus.BUSY     = 1'b1;
        bus.DONE     = 1'b0;
        unique case (state_q)
            IDLE: bus.BUSY = 1'b0;
            LOAD: begin
                bus.CNT_LD   = 1'b1;
                bus.PROD_LD  = 1'b1;
                bus.PROD_SEL = PROD_ONE;
            end
            CHECK: ;
            MULT: begin
                bus.CNT_EN   = 1'b1;
                bus.PROD_LD  = 1'b1;
                bus.PROD_SEL = PROD_MUL;
            end
            FIN:  bus.DONE = 1'b1;
            default: bus.BUSY = 1'b0;
        endcase
    end

    assign bus.CNT_D = n_q;
    assign bus.ERR   = err_q;

endmodule

// File: tb/tb_fact_ctrl.sv
// tb/tb_fact_ctrl.sv - self-checking bench for fact_ctrl with counter/product datapath model
module tb_fact_ctrl;

    localparam int WIDTH = 4;
    localparam int MAX_N = 12;

    logic CLK;
    logic RST_N;

    fact_ctrl_if #(.WIDTH(WIDTH)) bus ();

    fact_ctrl #(.WIDTH(WIDTH), .MAX_N(MAX_N)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Datapath environment: load-then-decrement counter, 32-bit product register
    logic [WIDTH-1:0] cnt;
    logic [31:0]      prod;

    assign bus.CNT_Q = cnt;

    always @(posedge CLK) begin
        if (!RST_N) begin
            cnt  <= '0;
            prod <= '0;
        end else begin
            if (bus.CNT_LD)      cnt <= bus.CNT_D;
            else if (bus.CNT_EN) cnt <= cnt - 1'b1;
            if (bus.PROD_LD)     prod <= bus.PROD_SEL ? prod * 32'(cnt) : 32'd1;
        end
    end

    function automatic logic [31:0] fact(input int n);
        logic [31:0] r = 32'd1;
        for (int i = 2; i <= n; i++) r = r * 32'(i);
        return r;
    endfunction

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"}, 32'(bus.BUSY), 32'd0);
        check_val({tag, "_strobes"},
                  32'({bus.CNT_LD, bus.CNT_EN, bus.PROD_LD, bus.PROD_SEL, bus.DONE}), 32'd0);
    endtask

    // mode 0: plain run, 1: extra GO mid-run, 2: reset in a MULT cycle
    task automatic run_op(input int n, input int mode);
        int k, lat, en_cnt, ld_cnt, pl_cnt, busy_cnt, ovl, exp_lat, exp_en, exp_pl;
        bit done_seen;
        @(negedge CLK);
        bus.GO = 1'b1;
        bus.N  = WIDTH'(n);
        @(posedge CLK);
        #1 bus.GO = 1'b0;
        if (n > MAX_N) begin
            @(negedge CLK);
            check_val($sformatf("err_set_n%0d", n), 32'(bus.ERR), 32'd1);
            check_quiet("reject");
            return;
        end
        exp_lat = (n <= 1) ? 3 : 3 + 2 * (n - 1);
        exp_en  = (n <= 1) ? 0 : n - 1;
        exp_pl  = (n <= 1) ? 1 : n;
        {en_cnt, ld_cnt, pl_cnt, busy_cnt, ovl, lat} = '0;
        done_seen = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge CLK);
            busy_cnt += int'(bus.BUSY);
            en_cnt   += int'(bus.CNT_EN);
            ld_cnt   += int'(bus.CNT_LD);
            pl_cnt   += int'(bus.PROD_LD);
            ovl      += int'(bus.CNT_LD & bus.CNT_EN);
            if (mode == 1 && k == 3) begin
                bus.GO = 1'b1;
                bus.N  = 4'd7;
            end
            if (mode == 1 && k == 4) bus.GO = 1'b0;
            if (mode == 2 && k == 3) begin
                check_val("rst_in_mult", 32'(bus.CNT_EN), 32'd1);
                RST_N = 1'b0;
                @(negedge CLK);
                check_quiet("rst");
                check_val("rst_cnt_d", 32'(bus.CNT_D), 32'd0);
                check_val("rst_err", 32'(bus.ERR), 32'd0);
                RST_N = 1'b1;
                pl_cnt = 0;
                for (int j = 0; j < 5; j++) begin
                    @(negedge CLK);
                    pl_cnt += int'(bus.CNT_LD | bus.CNT_EN | bus.PROD_LD | bus.BUSY);
                end
                check_val("rst_no_strobes", 32'(pl_cnt), 32'd0);
                return;
            end
            if (bus.DONE) begin
                done_seen = 1'b1;
                lat = k;
                break;
            end
        end
        check_val($sformatf("done_seen_n%0d", n), 32'(done_seen), 32'd1);
        check_val($sformatf("latency_n%0d", n), 32'(lat), 32'(exp_lat));
        check_val($sformatf("product_n%0d", n), prod, fact(n));
        check_val($sformatf("cnt_en_n%0d", n), 32'(en_cnt), 32'(exp_en));
        check_val($sformatf("cnt_ld_n%0d", n), 32'(ld_cnt), 32'd1);
        check_val($sformatf("prod_ld_n%0d", n), 32'(pl_cnt), 32'(exp_pl));
        check_val($sformatf("ld_en_overlap_n%0d", n), 32'(ovl), 32'd0);
        check_val($sformatf("busy_cycles_n%0d", n), 32'(busy_cnt), 32'(exp_lat));
        check_val($sformatf("n_reg_n%0d", n), 32'(bus.CNT_D), 32'(n));
        check_val($sformatf("err_clear_n%0d", n), 32'(bus.ERR), 32'd0);
        @(negedge CLK);
        check_val($sformatf("idle_after_n%0d", n), 32'(bus.BUSY), 32'd0);
    endtask

    initial begin
        bit got_done;
        RST_N  = 1'b0;
        bus.GO = 1'b0;
        bus.N  = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_quiet("reset");
        check_val("reset_cnt_d", 32'(bus.CNT_D), 32'd0);
        check_val("reset_err", 32'(bus.ERR), 32'd0);
        RST_N = 1'b1;

        run_op(5, 0);
        run_op(0, 0);
        run_op(1, 0);
        run_op(12, 0);
        run_op(13, 0);
        run_op(3, 0);
        run_op(4, 1);
        run_op(6, 2);
        run_op(3, 0);

        // GO held high across FIN re-launches from the following IDLE cycle
        @(negedge CLK);
        bus.GO = 1'b1;
        bus.N  = 4'd0;
        got_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.DONE) begin
                got_done = 1'b1;
                break;
            end
        end
        check_val("held_go_done", 32'(got_done), 32'd1);
        @(negedge CLK);
        check_val("held_go_idle", 32'(bus.BUSY), 32'd0);
        @(negedge CLK);
        check_val("held_go_relaunch", 32'(bus.CNT_LD), 32'd1);
        bus.GO = 1'b0;
        repeat (4) @(negedge CLK);
        check_val("held_go_drained", 32'(bus.BUSY), 32'd0);

        for (int i = 0; i < 20; i++) run_op(int'($urandom_range(0, 15)), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
